// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank with compare: FSM state encoding
// and the bit order of the {gt,eq,lt} compare result.
package reg_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Bit positions inside the packed compare result {gt,eq,lt}
  localparam int CMP_GT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

  typedef logic [2:0] cmp_t;

endpackage

// File: rtl/reg_bank_cmp_if.sv
// Bus bundle for reg_bank_cmp: write port, dual read/compare port, clear
// control, and a debug view of the FSM state.
interface reg_bank_cmp_if
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              clr;
  logic              busy;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;
  logic              gt;
  logic              eq;
  logic              lt;
  state_t            state_dbg;

  // Requests are single-cycle strobes sampled on the rising clock edge and
  // honoured only while busy=0; rd_valid is a one-cycle pulse, one cycle
  // after the accepted rd_req, and the read outputs hold between pulses.
  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr_a, rd_addr_b, clr,
    input  busy, rd_valid, rd_a, rd_b, gt, eq, lt, state_dbg
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr_a, rd_addr_b, clr,
    output busy, rd_valid, rd_a, rd_b, gt, eq, lt, state_dbg
  );

endinterface

// File: rtl/reg_cmp.sv
// Combinational magnitude compare of a against b, unsigned or two's-complement
// depending on SIGNED; result packed as {gt,eq,lt}.
module reg_cmp
  import reg_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_t             res
);

  logic a_gt;

  always_comb begin
    if (SIGNED != 0) a_gt = $signed(a) > $signed(b);
    else             a_gt = a > b;
    res         = '0;
    res[CMP_GT] = a_gt;
    res[CMP_EQ] = (a == b);
    res[CMP_LT] = !a_gt && (a != b);
  end

endmodule

// File: rtl/reg_bank_cmp.sv
// Small register bank with a registered two-operand read-and-compare port and
// a DEPTH-cycle clear-all sweep controlled by a two-state FSM.
module reg_bank_cmp
  import reg_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SIGNED = 0,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst_n,
  reg_bank_cmp_if.slave bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              idle, wr_ok, rd_ok;
  logic [WIDTH-1:0]  fwd_a, fwd_b;
  cmp_t              cmp_res, cmp_q;
  logic              rd_valid_q;
  logic [WIDTH-1:0]  rd_a_q, rd_b_q;

  assign idle  = (state == IDLE);
  // clr wins over a same-cycle write, so a dropped write must not forward either
  assign wr_ok = idle && bus.wr_en && !bus.clr;
  assign rd_ok = idle && bus.rd_req;

  assign fwd_a = (wr_ok && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data : mem[bus.rd_addr_a];
  assign fwd_b = (wr_ok && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data : mem[bus.rd_addr_b];

  reg_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp (
    .a   (fwd_a),
    .b   (fwd_b),
    .res (cmp_res)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!idle) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q     <= 1'b0;
      rd_a_q         <= '0;
      rd_b_q         <= '0;
      cmp_q          <= '0;
      cmp_q[CMP_EQ]  <= 1'b1;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) begin
        rd_a_q <= fwd_a;
        rd_b_q <= fwd_b;
        cmp_q  <= cmp_res;
      end
    end
  end

  assign bus.busy      = !idle;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_a      = rd_a_q;
  assign bus.rd_b      = rd_b_q;
  assign bus.gt        = cmp_q[CMP_GT];
  assign bus.eq        = cmp_q[CMP_EQ];
  assign bus.lt        = cmp_q[CMP_LT];
  assign bus.state_dbg = state;

endmodule

// File: doc/reg_bank_cmp.md
REG_BANK_CMP -- requirements
Module: reg_bank_cmp

Interface
REQ-001 Parameter WIDTH, default 8: data width of every register entry and data port.
REQ-002 Parameter DEPTH, default 4: number of entries; power of two, minimum 2.
REQ-003 Parameter SIGNED, default 0: 0 selects unsigned compare, 1 selects two's-complement compare.
REQ-004 Parameter ADDR_W, default $clog2(DEPTH): address width; derived, never overridden.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  write strobe.
REQ-008 wr_addr  in  ADDR_W  write address.
REQ-009 wr_data  in  WIDTH  write data.
REQ-010 rd_req  in  1  read-and-compare request.
REQ-011 rd_addr_a / rd_addr_b  in  ADDR_W each  read addresses for operands A and B.
REQ-012 clr  in  1  start a clear-all sweep.
REQ-013 busy  out  1  high while the clear sweep runs.
REQ-014 rd_valid  out  1  one-cycle pulse qualifying rd_a, rd_b, gt, eq and lt.
REQ-015 rd_a / rd_b  out  WIDTH each  registered read data.
REQ-016 gt / eq / lt  out  1 each  registered compare of rd_a against rd_b; exactly one is high when rd_valid=1.

Function
REQ-017 The FSM SHALL have two states: IDLE and CLEAR.
REQ-018 In IDLE, clr=1 SHALL move the FSM to CLEAR and load the sweep counter with 0.
REQ-019 In CLEAR, each cycle SHALL zero the entry at the counter and increment the counter.
REQ-020 After zeroing entry DEPTH-1, the FSM SHALL return to IDLE; the sweep lasts exactly DEPTH cycles.
REQ-021 busy SHALL be high in exactly those DEPTH cycles.
REQ-022 In CLEAR, wr_en, rd_req and clr SHALL be ignored, and rd_valid SHALL stay 0.
REQ-023 In IDLE, wr_en=1 SHALL write wr_data to wr_addr at the clock edge.
REQ-024 In IDLE, rd_req=1 SHALL produce rd_valid=1 on the next cycle, with rd_a and rd_b holding the addressed entries; read latency is 1.
REQ-025 A same-cycle write and read to the same address SHALL forward wr_data to that read operand (write-through).
REQ-026 If rd_addr_a equals rd_addr_b, both operands SHALL return the same value and eq SHALL be 1.
REQ-027 Comparison SHALL use the full WIDTH bits, signed or unsigned per the SIGNED parameter.
REQ-028 When rd_valid=0, rd_a, rd_b, gt, eq and lt SHALL hold their last values.
REQ-029 If clr and wr_en are both high in IDLE, clr SHALL win and the write SHALL be dropped.
REQ-030 If clr and rd_req are both high in IDLE, the read SHALL still complete, using pre-clear data.
REQ-031 The sweep counter SHALL be ADDR_W bits wide and wrap to 0 at the end of the sweep.

Reset
REQ-032 rst_n=0 SHALL asynchronously force the state to IDLE, all entries and the counter to 0, and busy, rd_valid, rd_a, rd_b, gt and lt to 0, with eq at 1.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep; after release the FSM is IDLE with every entry 0.
REQ-034 After rst_n rises, the first edge SHALL be able to accept a write or read.

Structure
REQ-035 The state encoding (IDLE=1'b0, CLEAR=1'b1) SHALL live in a shared package/include, reg_bank_pkg.
REQ-036 The compare-result bit order {gt,eq,lt} SHALL also live in reg_bank_pkg.
REQ-037 The compare logic SHALL be a combinational sub-module, reg_cmp, with parameters WIDTH and SIGNED.
REQ-038 The storage array and FSM SHALL stay in reg_bank_cmp.

Verification
REQ-039 Reset check: hold rst_n low, then release -> all outputs at their reset values; a read of every address returns 0.
REQ-040 Write/read, defaults: write 8'hAA@0 and 8'h55@1, read a=0, b=1 -> next cycle rd_valid=1, rd_a=AA, rd_b=55, gt=1.
REQ-041 Signed compare, SIGNED=1: write 8'hFF@2 and 8'h01@3, read a=2, b=3 -> lt=1; with SIGNED=0 the same read -> gt=1.
REQ-042 Forwarding: wr_en with 8'h3C@1 and rd_req a=1, b=1 in the same cycle -> rd_a=rd_b=3C, eq=1.
REQ-043 Clear sweep: pulse clr with DEPTH=4 -> busy high 4 cycles; wr_en and rd_req during busy have no effect; reads afterwards return 0.
REQ-044 Reset mid-sweep: assert rst_n low in the second busy cycle -> busy=0 immediately; FSM IDLE with all entries 0 after release.
